// File: rtl/sram_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_bus_arbiter_if
// Description : Requester handshake and multiplexed SRAM pin bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_bus_arbiter_if #(
    parameter int W = 8
);
    logic         req0;
    logic         req1;
    logic         we0;
    logic         we1;
    logic [W-1:0] addr0;
    logic [W-1:0] addr1;
    logic [W-1:0] wdata0;
    logic [W-1:0] wdata1;
    logic         ack0;
    logic         ack1;
    logic [W-1:0] rdata;
    logic         busy;
    logic [W-1:0] bus_din;
    logic [W-1:0] bus_dout;
    logic [W-1:0] bus_oe;
    logic         latch_le;
    logic         mem_oe_n;
    logic         mem_we_n;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, bus_din,
        output ack0, ack1, rdata, busy, bus_dout, bus_oe, latch_le, mem_oe_n, mem_we_n
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, bus_din,
        input  ack0, ack1, rdata, busy, bus_dout, bus_oe, latch_le, mem_oe_n, mem_we_n
    );
endinterface
`default_nettype wire

// File: rtl/sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_bus_arbiter
// Description : Two-port arbiter driving a latched-address multiplexed SRAM
//               bus. Define SRAM_ARB_RR_EN for round-robin ties, else port 1
//               always wins ties.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_bus_arbiter #(
    parameter int W = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    sram_bus_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_HOLD    = 3'd2,
        S_OE      = 3'd3,
        S_SAMPLE  = 3'd4,
        S_DATA    = 3'd5,
        S_STROBE  = 3'd6,
        S_RECOVER = 3'd7
    } state_t;

    localparam logic [W-1:0] C_ALL_ONES = {W{1'b1}};

    state_t       state_q, state_d;
    logic         sel_q, sel_d;
    logic         we_q, we_d;
    logic [W-1:0] addr_q, addr_d;
    logic [W-1:0] wdata_q, wdata_d;
    logic         latch_le_q, latch_le_d;
    logic         mem_oe_n_q, mem_oe_n_d;
    logic         mem_we_n_q, mem_we_n_d;
    logic [W-1:0] bus_oe_q, bus_oe_d;
    logic [W-1:0] bus_dout_q, bus_dout_d;
    logic [W-1:0] rdata_q, rdata_d;
    logic         ack0_q, ack0_d;
    logic         ack1_q, ack1_d;
    logic         busy_q, busy_d;
    logic         grant_port;

`ifdef SRAM_ARB_RR_EN
    // rr_q names the port that wins the next tie.
    logic rr_q, rr_d;
    assign grant_port = (bus.req0 && bus.req1) ? rr_q : bus.req1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_q <= 1'b0;
        else        rr_q <= rr_d;
    end
`else
    assign grant_port = bus.req1;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef SRAM_ARB_RR_EN
        rr_d    = rr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    sel_d   = grant_port;
                    we_d    = grant_port ? bus.we1    : bus.we0;
                    addr_d  = grant_port ? bus.addr1  : bus.addr0;
                    wdata_d = grant_port ? bus.wdata1 : bus.wdata0;
`ifdef SRAM_ARB_RR_EN
                    rr_d    = ~grant_port;
`endif
                    state_d = S_ADDR;
                end
            end
            S_ADDR:    state_d = S_HOLD;
            S_HOLD:    state_d = we_q ? S_DATA : S_OE;
            S_OE:      state_d = S_SAMPLE;
            S_SAMPLE:  state_d = S_IDLE;
            S_DATA:    state_d = S_STROBE;
            S_STROBE:  state_d = S_RECOVER;
            S_RECOVER: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Pin outputs are decoded from the next state so they are registered
    // yet valid in the very cycle the state is entered.
    always_comb begin
        latch_le_d = 1'b0;
        mem_oe_n_d = 1'b1;
        mem_we_n_d = 1'b1;
        bus_oe_d   = '0;
        bus_dout_d = bus_dout_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        busy_d     = (state_d != S_IDLE);
        rdata_d    = (state_q == S_OE) ? bus.bus_din : rdata_q;
        case (state_d)
            S_ADDR: begin
                latch_le_d = 1'b1;
                bus_oe_d   = C_ALL_ONES;
                bus_dout_d = addr_d;
            end
            S_HOLD: begin
                bus_oe_d   = C_ALL_ONES;
                bus_dout_d = addr_d;
            end
            S_OE:      mem_oe_n_d = 1'b0;
            S_SAMPLE: begin
                ack0_d = ~sel_d;
                ack1_d = sel_d;
            end
            S_DATA: begin
                bus_oe_d   = C_ALL_ONES;
                bus_dout_d = wdata_d;
            end
            S_STROBE: begin
                mem_we_n_d = 1'b0;
                bus_oe_d   = C_ALL_ONES;
                bus_dout_d = wdata_d;
            end
            S_RECOVER: begin
                bus_oe_d   = C_ALL_ONES;
                bus_dout_d = wdata_d;
                ack0_d     = ~sel_d;
                ack1_d     = sel_d;
            end
            default:   latch_le_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sel_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            latch_le_q <= 1'b1;
            mem_oe_n_q <= 1'b1;
            mem_we_n_q <= 1'b1;
            bus_oe_q   <= '0;
            bus_dout_q <= '0;
            rdata_q    <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            latch_le_q <= latch_le_d;
            mem_oe_n_q <= mem_oe_n_d;
            mem_we_n_q <= mem_we_n_d;
            bus_oe_q   <= bus_oe_d;
            bus_dout_q <= bus_dout_d;
            rdata_q    <= rdata_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.latch_le = latch_le_q;
    assign bus.mem_oe_n = mem_oe_n_q;
    assign bus.mem_we_n = mem_we_n_q;
    assign bus.bus_oe   = bus_oe_q;
    assign bus.bus_dout = bus_dout_q;
    assign bus.rdata    = rdata_q;
    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sram_bus_arbiter
// Description : Directed and random traffic against a transaction-level model
//               of the arbiter plus a pin-level SRAM with external latch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_bus_arbiter;
    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    sram_bus_arbiter_if #(.W(W)) bus ();
    sram_bus_arbiter #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] dflt(input logic [7:0] a);
        return a ^ 8'h4A;
    endfunction

    // Pin-level SRAM behind a transparent address latch.
    logic [7:0] ext_lat;
    logic [7:0] pmem [256];
    bit         pval [256];
    logic [7:0] junk;
    always @(posedge clk) begin
        junk <= 8'($urandom);
        if (bus.latch_le) ext_lat <= bus.bus_dout;
        if (!bus.mem_we_n) begin
            pmem[ext_lat] <= bus.bus_dout;
            pval[ext_lat] <= 1'b1;
        end
    end
    assign bus.bus_din = !bus.mem_oe_n ? (pval[ext_lat] ? pmem[ext_lat] : dflt(ext_lat)) : junk;

    // Transaction-level reference: phase counts cycles into the current grant.
    int         m_phase = 0;
    bit         m_we = 0, m_port = 0, m_rr = 0;
    logic [7:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
    logic [7:0] gmem [256];
    bit         gval [256];

    initial forever begin
        int         last;
        logic [5:0] e_ctrl;
        logic [7:0] e_oe;
        bit         p;
        @(negedge clk);
        if (!rst_n) begin
            m_phase = 0; m_rr = 0; m_rdata = 8'h00;
            chk("rst_ctrl", {bus.latch_le, bus.mem_oe_n, bus.mem_we_n, bus.busy, bus.ack0, bus.ack1}, 6'b111000);
            chk("rst_bus", {bus.bus_oe, bus.bus_dout, bus.rdata}, 24'h0);
        end else begin
            last   = m_we ? 5 : 4;
            e_ctrl = {m_phase <= 1, !(!m_we && m_phase == 3), !(m_we && m_phase == 4),
                      m_phase != 0, (m_phase == last) && !m_port, (m_phase == last) && m_port};
            e_oe   = (m_phase == 1 || m_phase == 2 || (m_we && m_phase >= 3)) ? 8'hFF : 8'h00;
            chk("ctrl{le,oe_n,we_n,busy,ack0,ack1}",
                {bus.latch_le, bus.mem_oe_n, bus.mem_we_n, bus.busy, bus.ack0, bus.ack1}, e_ctrl);
            chk("bus_oe", bus.bus_oe, e_oe);
            if (e_oe == 8'hFF) chk("bus_dout", bus.bus_dout, (m_phase <= 2) ? m_addr : m_wdata);
            chk("rdata", bus.rdata, m_rdata);
            chk("inv_oe_we", !bus.mem_oe_n && !bus.mem_we_n, 0);
            chk("inv_contention", (bus.bus_oe == 8'hFF) && !bus.mem_oe_n, 0);
            chk("inv_latch", bus.latch_le && (!bus.mem_oe_n || !bus.mem_we_n), 0);
            if (m_phase == 0) begin
                if (bus.req0 || bus.req1) begin
`ifdef SRAM_ARB_RR_EN
                    p    = (bus.req0 && bus.req1) ? m_rr : bus.req1;
                    m_rr = !p;
`else
                    p    = bus.req1;
`endif
                    m_port  = p;
                    m_we    = p ? bus.we1 : bus.we0;
                    m_addr  = p ? bus.addr1 : bus.addr0;
                    m_wdata = p ? bus.wdata1 : bus.wdata0;
                    m_phase = 1;
                end
            end else begin
                if (!m_we && m_phase == 3) m_rdata = gval[m_addr] ? gmem[m_addr] : dflt(m_addr);
                if (m_we && m_phase == 4) begin
                    gmem[m_addr] = m_wdata;
                    gval[m_addr] = 1'b1;
                end
                m_phase = (m_phase == last) ? 0 : m_phase + 1;
            end
        end
    end

    task automatic txn(input bit p, input bit we, input logic [7:0] a, input logic [7:0] d,
                       output int cyc, output int oelo, output int welo,
                       output logic [7:0] d_addr, output logic [7:0] d_data,
                       output logic [1:0] le, output logic [7:0] rd);
        bit done;
        @(posedge clk); #1;
        if (p) begin bus.req1 = 1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; end
        else   begin bus.req0 = 1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; end
        cyc = 0; oelo = 0; welo = 0; d_addr = 0; d_data = 0; le = 0; rd = 0; done = 0;
        @(posedge clk);
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            cyc++;
            if (!bus.mem_oe_n) oelo++;
            if (!bus.mem_we_n) welo++;
            if (cyc == 1) begin d_addr = bus.bus_dout; le[1] = bus.latch_le; end
            if (cyc == 2) le[0] = bus.latch_le;
            if (cyc == 3) d_data = bus.bus_dout;
            if (p ? bus.ack1 : bus.ack0) begin done = 1; rd = bus.rdata; end
        end
        chk("txn_ack_seen", done, 1);
        @(posedge clk); #1;
        if (p) bus.req1 = 0; else bus.req0 = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cyc, oelo, welo, n, a0, a1;
        logic [7:0] d_addr, d_data, rd;
        logic [1:0] le;
        logic [3:0] order;
        bit         rq [2];
        bit         pa [2];
        bit         rw [2];
        logic [7:0] ra [2];
        logic [7:0] rdd [2];

        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("reset_latch_le", bus.latch_le, 1);
        chk("reset_strobes", {bus.mem_oe_n, bus.mem_we_n}, 2'b11);
        chk("reset_bus_oe_dout", {bus.bus_oe, bus.bus_dout}, 16'h0);
        chk("reset_rdata_ack_busy", {bus.rdata, bus.ack0, bus.ack1, bus.busy}, 11'h0);

        // Port 0 read of 0x10; SRAM default content there is 0x5A.
        txn(0, 0, 8'h10, 8'h00, cyc, oelo, welo, d_addr, d_data, le, rd);
        chk("rd_ack_cycle", cyc, 4);
        chk("rd_oe_low_cycles", oelo, 1);
        chk("rd_we_low_cycles", welo, 0);
        chk("rd_addr_driven", d_addr, 8'h10);
        chk("rd_latch_1_then_0", le, 2'b10);
        chk("rd_data", rd, 8'h5A);

        txn(1, 1, 8'h20, 8'hC3, cyc, oelo, welo, d_addr, d_data, le, rd);
        chk("wr_ack_cycle", cyc, 5);
        chk("wr_we_low_cycles", welo, 1);
        chk("wr_oe_low_cycles", oelo, 0);
        chk("wr_addr_driven", d_addr, 8'h20);
        chk("wr_data_driven", d_data, 8'hC3);
        chk("wr_rdata_unchanged", rd, 8'h5A);

        txn(0, 0, 8'h20, 8'h00, cyc, oelo, welo, d_addr, d_data, le, rd);
        chk("readback_0x20", rd, 8'hC3);

        // Continuous contention from a fresh reset.
        @(posedge clk); #1 rst_n = 0;
        @(posedge clk); #1 rst_n = 1;
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'h01;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 8'h02;
        @(posedge clk);
        n = 0; cyc = 0; order = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clk);
            cyc++;
            if (bus.ack0) begin order = {order[2:0], 1'b0}; n++; end
            if (bus.ack1) begin order = {order[2:0], 1'b1}; n++; end
        end
        @(posedge clk); #1 bus.req0 = 0; bus.req1 = 0;
        chk("contend_count", n, 4);
        chk("contend_4th_ack_cycle", cyc, 19);
`ifdef SRAM_ARB_RR_EN
        chk("contend_grant_order", order, 4'b0101);
`else
        chk("contend_grant_order", order, 4'b1111);
`endif
        repeat (2) @(posedge clk);

        // req0 dropped in HOLD; req1 raised and withdrawn before IDLE.
        @(posedge clk); #1 bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'h33;
        @(posedge clk);
        @(posedge clk); #1 bus.req0 = 0;
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 8'h44; bus.wdata1 = 8'h99;
        @(posedge clk); #1 bus.req1 = 0;
        a0 = 0; a1 = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            a0 += int'(bus.ack0);
            a1 += int'(bus.ack1);
        end
        chk("dropped_req0_ack", a0, 1);
        chk("withdrawn_req1_ack", a1, 0);
        chk("dropped_req0_rdata", bus.rdata, 8'h79);

        // Reset asserted in the middle of a write strobe.
        @(posedge clk); #1 bus.req1 = 1; bus.we1 = 1; bus.addr1 = 8'h55; bus.wdata1 = 8'h66;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 chk("strobe_reached", bus.mem_we_n, 0);
        #1 rst_n = 0; bus.req1 = 0;
        #1;
        chk("async_rst_we_n", bus.mem_we_n, 1);
        chk("async_rst_bus_oe", bus.bus_oe, 8'h00);
        chk("async_rst_latch_le", bus.latch_le, 1);
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        chk("post_rst_busy", bus.busy, 0);

        // Random mixed traffic on a small address window.
        rq[0] = 0; rq[1] = 0; pa[0] = 0; pa[1] = 0;
        rw[0] = 0; rw[1] = 0; ra[0] = 0; ra[1] = 0; rdd[0] = 0; rdd[1] = 0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (pa[p] && rq[p]) begin
                    if ($urandom_range(1) == 0) rq[p] = 0;
                    else begin
                        rw[p] = 1'($urandom_range(1)); ra[p] = {4'h8, 4'($urandom_range(15))}; rdd[p] = 8'($urandom);
                    end
                end else if (!rq[p]) begin
                    if ($urandom_range(2) == 0) begin
                        rq[p] = 1; rw[p] = 1'($urandom_range(1));
                        ra[p] = {4'h8, 4'($urandom_range(15))}; rdd[p] = 8'($urandom);
                    end
                end else if ($urandom_range(31) == 0) begin
                    rq[p] = 0;
                end
            end
            bus.req0 = rq[0]; bus.we0 = rw[0]; bus.addr0 = ra[0]; bus.wdata0 = rdd[0];
            bus.req1 = rq[1]; bus.we1 = rw[1]; bus.addr1 = ra[1]; bus.wdata1 = rdd[1];
            pa[0] = bus.ack0; pa[1] = bus.ack1;
        end
        @(posedge clk); #1 bus.req0 = 0; bus.req1 = 0;
        for (int i = 0; i < 20 && bus.busy; i++) @(negedge clk);
        @(negedge clk);
        chk("drain_idle", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sram_bus_arbiter.md
# sram_bus_arbiter

Shares the single external address-latch + SRAM bus between two requesters: port 0 (SUBNEG core) and port 1 (host loader/debug). Each port issues single-byte read or write transactions over a req/ack handshake. The arbiter grants one port and runs the multiplexed bus cycle: latch address, release latch, then OE read or WE write. The block sits between the core/loader and the chip pins (`uio_*`, `uo_out[2:0]`).

## Interface
- `W`, 8: address and data width; the bus is multiplexed, so the two widths are equal.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0` / `req1` in 1: transaction request, held until `ackN`.
- `we0` / `we1` in 1: 1 = write, 0 = read. Stable while `reqN` is high.
- `addr0` / `addr1` in W: SRAM address. Stable while `reqN` is high.
- `wdata0` / `wdata1` in W: write data. Stable while `reqN` is high.
- `ack0` / `ack1` out 1: one-cycle completion pulse.
- `rdata` out W: last read byte, shared by both ports. Valid in the ack cycle; held until the next read completes.
- `busy` out 1: high whenever the state is not IDLE.
- `bus_din` in W: pin input (`uio_in`).
- `bus_dout` out W: pin output (`uio_out`).
- `bus_oe` out W: pin direction, all ones = drive, all zeros = input.
- `latch_le` out 1: external address latch enable; transparent while high.
- `mem_oe_n` out 1: SRAM output enable, active low.
- `mem_we_n` out 1: SRAM write enable, active low.

## Operation
- Reset values:
  - `latch_le` = 1, `mem_oe_n` = 1, `mem_we_n` = 1.
  - `bus_oe` = 0x00, `bus_dout` = 0x00, `rdata` = 0x00.
  - `ack0` = `ack1` = 0, `busy` = 0, state = IDLE, round-robin pointer = port 0.
- All outputs are registered. Assertion of `rst_n` low forces them to their reset values immediately, even in the middle of a bus cycle.
- States: IDLE, ADDR, HOLD, then a read path or a write path.
  - Read path: OE, SAMPLE.
  - Write path: DATA, STROBE, RECOVER.
- IDLE:
  - Outputs: `latch_le`=1, `mem_oe_n`=1, `mem_we_n`=1, `bus_oe`=0x00.
  - If any `reqN` is sampled high, choose the winner, latch its addr/we/wdata internally, and go to ADDR.
- ADDR: `bus_dout`=addr, `bus_oe`=all ones, `latch_le`=1. Next state HOLD.
- HOLD: `latch_le`=0, address still driven. Next state OE if read, DATA if write.
- Read path:
  - OE: `bus_oe`=0x00, `mem_oe_n`=0. The edge leaving OE captures `bus_din` into `rdata`. Next state SAMPLE.
  - SAMPLE: `mem_oe_n`=1, `ackN`=1 for the granted port. Next state IDLE.
- Write path:
  - DATA: `bus_dout`=wdata, `bus_oe`=all ones. Next state STROBE.
  - STROBE: `mem_we_n`=0. Next state RECOVER.
  - RECOVER: `mem_we_n`=1, data still driven, `ackN`=1. Next state IDLE.
- Invariants:
  - `mem_oe_n` and `mem_we_n` are never both 0.
  - `bus_oe` is never all ones while `mem_oe_n`=0.
  - `latch_le` is 0 whenever `mem_oe_n`=0 or `mem_we_n`=0.
- Handshake rules:
  - A requester drops `reqN`, or presents a new transaction, on the edge where it observes `ackN`.
  - `reqN` high in IDLE is always treated as a new transaction.
  - If `reqN` drops after grant, the cycle still completes and `ackN` still pulses.
  - A `reqN` that is withdrawn before being sampled in IDLE is never issued.
- Arbitration is decided only in IDLE. The loser's request stays pending and has no timeout.

## Timing
- Read: `req` is sampled at edge E. States run ADDR, HOLD, OE, SAMPLE in cycles E+1 through E+4. `ack` is high in cycle E+4.
- Write: states run ADDR, HOLD, DATA, STROBE, RECOVER in cycles E+1 through E+5. `ack` is high in cycle E+5.
- Every transaction is followed by at least one IDLE cycle.
  - Back-to-back reads: 5 cycles each.
  - Back-to-back writes: 6 cycles each.
- Simultaneous `req0` and `req1` in IDLE: exactly one is granted per the configured policy. The other is granted at the next IDLE in which it is still asserted.

## Configuration
- `SRAM_ARB_RR_EN` defined: round-robin arbitration.
  - On a tie, the port not granted last wins.
  - The pointer updates on each grant.
  - With continuous requests from both ports, grants alternate.
- `SRAM_ARB_RR_EN` undefined: fixed priority, port 1 (host) always wins ties. The round-robin pointer logic is not built.

## Test plan
- Reset, then port 0 reads 0x10 with `bus_din`=0x5A driven during OE:
  - `bus_dout`=0x10 during ADDR/HOLD, `latch_le` 1→0.
  - `mem_oe_n` low for exactly 1 cycle.
  - `ack0` in cycle E+4, `rdata`=0x5A.
- Port 1 writes 0xC3 to 0x20:
  - ADDR drives 0x20, DATA drives 0xC3.
  - `mem_we_n` low only in STROBE.
  - `ack1` in cycle E+5; `rdata` unchanged.
- Both ports request reads continuously for 4 transactions:
  - With RR: grant order 0,1,0,1.
  - Without: 1,1,1,1 and `ack0` never fires.
- `req0` dropped during HOLD: the cycle finishes and `ack0` still pulses. A `req1` withdrawn while port 0's cycle is in progress and before IDLE is never issued.
- `rst_n` low during STROBE: `mem_we_n`=1, `bus_oe`=0x00, `latch_le`=1 before the next clock edge. After release the state is IDLE and `busy`=0.
- Random mixed traffic with an SRAM model: check the OE/WE exclusivity, bus-contention and latch invariants every cycle, and check read-after-write data.
